s27_bist_driver: RTL and testbench



---
 rtl/s27_bist_driver.sv | 112 +++++++++++
 tb/tb_s27_bist_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/s27_bist_driver.sv
// rtl/s27_bist_driver.sv - BIST driver for the s27 benchmark: warm-up, LFSR patterns, CRC-16 signature
// Drives G0..G3, compacts G17 serially and flags pass/fail against a golden signature.
module s27_bist_driver #(
   parameter int unsigned N_PATTERNS = 64,
   parameter int unsigned WARMUP     = 2,
   parameter logic [7:0]  LFSR_SEED  = 8'h01,
   parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
   input  logic        CK,
   input  logic        RST,
   input  logic        START,
   input  logic        G17,
   output logic        G0,
   output logic        G1,
   output logic        G2,
   output logic        G3,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS,
   output logic [15:0] SIGNATURE
);

   // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
   localparam logic [7:0]  SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [15:0] LAST_WARM = 16'(WARMUP - 1);
   localparam logic [15:0] LAST_RUN  = 16'(N_PATTERNS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARM,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d;
   logic [7:0]  lfsr, lfsr_d;
   logic [15:0] sig, sig_d;
   logic        pass, pass_d;
   logic [3:0]  pattern;
   logic [15:0] sig_step;
   logic [7:0]  lfsr_step;

   assign sig_step  = {sig[14:0], 1'b0} ^ ((sig[15] ^ G17) ? 16'h1021 : 16'h0000);
   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   always_ff @(posedge CK) begin
      if (RST) begin
         state <= ST_IDLE;
         cnt   <= 16'd0;
         lfsr  <= SEED;
         sig   <= 16'h0000;
         pass  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         lfsr  <= lfsr_d;
         sig   <= sig_d;
         pass  <= pass_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      lfsr_d  = lfsr;
      sig_d   = sig;
      pass_d  = pass;
      pattern = 4'hF;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d = ST_WARM;
               cnt_d   = 16'd0;
               lfsr_d  = SEED;
               sig_d   = 16'h0000;
               pass_d  = 1'b0;
            end
         end
         ST_WARM: begin
            if (cnt == LAST_WARM) begin
               state_d = ST_RUN;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
         ST_RUN: begin
            pattern = lfsr[3:0];
            sig_d   = sig_step;
            lfsr_d  = lfsr_step;
            if (cnt == LAST_RUN) begin
               state_d = ST_DONE;
               // Compare against the signature that includes this last G17 sample.
               pass_d  = (sig_step == GOLDEN_SIG);
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign {G3, G2, G1, G0} = pattern;
   assign BUSY      = (state == ST_WARM) || (state == ST_RUN);
   assign DONE      = (state == ST_DONE);
   assign PASS      = pass && (state == ST_DONE);
   assign SIGNATURE = sig;

endmodule

// File: tb/tb_s27_bist_driver.sv
// tb/tb_s27_bist_driver.sv - directed self-checking bench for s27_bist_driver
// Four drivers share CK/RST/START: defaults with G17=0, two short configs with G17=1, and one on an s27 model.
module tb_s27_bist_driver;

   logic CK = 1'b0;
   logic RST = 1'b1;
   logic START = 1'b0;
   logic g17_zero = 1'b0;
   logic g17_one = 1'b1;

   always #5 CK = ~CK;

   logic d_g0, d_g1, d_g2, d_g3, d_busy, d_done, d_pass;
   logic [15:0] d_sig;
   logic s_g0, s_g1, s_g2, s_g3, s_busy, s_done, s_pass;
   logic [15:0] s_sig;
   logic f_g0, f_g1, f_g2, f_g3, f_busy, f_done, f_pass;
   logic [15:0] f_sig;
   logic r_g0, r_g1, r_g2, r_g3, r_busy, r_done, r_pass, r_g17;
   logic [15:0] r_sig;

   s27_bist_driver u_def (
      .CK(CK), .RST(RST), .START(START), .G17(g17_zero),
      .G0(d_g0), .G1(d_g1), .G2(d_g2), .G3(d_g3),
      .BUSY(d_busy), .DONE(d_done), .PASS(d_pass), .SIGNATURE(d_sig)
   );

   s27_bist_driver #(.N_PATTERNS(2), .WARMUP(1), .GOLDEN_SIG(16'h3063)) u_small (
      .CK(CK), .RST(RST), .START(START), .G17(g17_one),
      .G0(s_g0), .G1(s_g1), .G2(s_g2), .G3(s_g3),
      .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .SIGNATURE(s_sig)
   );

   s27_bist_driver #(.N_PATTERNS(2), .WARMUP(1), .GOLDEN_SIG(16'h1021)) u_small_fail (
      .CK(CK), .RST(RST), .START(START), .G17(g17_one),
      .G0(f_g0), .G1(f_g1), .G2(f_g2), .G3(f_g3),
      .BUSY(f_busy), .DONE(f_done), .PASS(f_pass), .SIGNATURE(f_sig)
   );

   s27_bist_driver #(.N_PATTERNS(64)) u_real (
      .CK(CK), .RST(RST), .START(START), .G17(r_g17),
      .G0(r_g0), .G1(r_g1), .G2(r_g2), .G3(r_g3),
      .BUSY(r_busy), .DONE(r_done), .PASS(r_pass), .SIGNATURE(r_sig)
   );

   // s27 netlist; returns {G17, next G7, next G6, next G5}, st = {G7, G6, G5}.
   function automatic logic [3:0] s27_eval(input logic [3:0] g, input logic [2:0] st);
      logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
      g14 = ~g[0];
      g8  = g14 & st[1];
      g12 = ~(g[1] | st[2]);
      g15 = g12 | g8;
      g16 = g[3] | g8;
      g9  = ~(g16 & g15);
      g11 = ~(st[0] | g9);
      g10 = ~(g14 | g11);
      g13 = ~(g[2] | g12);
      return {~g11, g13, g11, g10};
   endfunction

   logic [2:0] s27_st;
   logic [3:0] s27_out;
   assign s27_out = s27_eval({r_g3, r_g2, r_g1, r_g0}, s27_st);
   assign r_g17 = s27_out[3];
   always_ff @(posedge CK) s27_st <= s27_out[2:0];

   function automatic logic [15:0] ref_signature();
      logic [2:0] st = 3'b001;
      logic [7:0] q = 8'h01;
      logic [15:0] s = 16'h0000;
      logic [3:0] o;
      for (int i = 0; i < 64; i++) begin
         o = s27_eval(q[3:0], st);
         if (s[15] ^ o[3]) s = {s[14:0], 1'b0} ^ 16'h1021;
         else              s = {s[14:0], 1'b0};
         st = o[2:0];
         q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
      end
      return s;
   endfunction

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   logic [15:0] ref_sig;
   logic [15:0] first_sig;
   logic [3:0] exp_pat [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

   // START pulse, then 67 sampled cycles with optional START pulses at cycles pa and pb.
   task automatic run_test(input int pa, input int pb, output int busy_n, output int done_at);
      busy_n = 0;
      done_at = 0;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int k = 1; k <= 67; k++) begin
         if (d_busy) busy_n++;
         if (d_done && done_at == 0) done_at = k;
         if (k <= 2) chk("warm_pattern", {12'h0, d_g3, d_g2, d_g1, d_g0}, 16'h000F);
         if (k >= 3 && k <= 7) chk("run_pattern", {12'h0, d_g3, d_g2, d_g1, d_g0}, {12'h0, exp_pat[k-3]});
         if (k == 3) chk("small_sig1", s_sig, 16'h1021);
         if (k == 4) begin
            chk("small_sig2", s_sig, 16'h3063);
            chk("small_done", {15'h0, s_done}, 16'h1);
            chk("small_pass", {15'h0, s_pass}, 16'h1);
            chk("small_fail_done", {15'h0, f_done}, 16'h1);
            chk("small_fail_pass", {15'h0, f_pass}, 16'h0);
         end
         START = (k == pa) || (k == pb);
         tick();
         START = 1'b0;
      end
   endtask

   int busy_n, done_at, done_seen;

   initial begin
      ref_sig = ref_signature();
      tick();
      tick();
      RST = 1'b0;
      chk("rst_pattern", {12'h0, d_g3, d_g2, d_g1, d_g0}, 16'h000F);
      chk("rst_busy", {15'h0, d_busy}, 16'h0);
      chk("rst_done", {15'h0, d_done}, 16'h0);
      chk("rst_pass", {15'h0, d_pass}, 16'h0);
      chk("rst_sig", d_sig, 16'h0000);

      run_test(0, 0, busy_n, done_at);
      chk("busy_cycles", 16'(busy_n), 16'd66);
      chk("done_cycle", 16'(done_at), 16'd67);
      chk("def_sig", d_sig, 16'h0000);
      chk("def_pass", {15'h0, d_pass}, 16'h1);
      chk("real_done", {15'h0, r_done}, 16'h1);
      chk("real_sig", r_sig, ref_sig);
      chk("real_pass", {15'h0, r_pass}, {15'h0, ref_sig == 16'h0000});
      first_sig = r_sig;

      // Restart from DONE with START pulses during RUN that must be ignored.
      run_test(10, 30, busy_n, done_at);
      chk("busy_cycles_2", 16'(busy_n), 16'd66);
      chk("done_cycle_2", 16'(done_at), 16'd67);
      chk("real_sig_repeat", r_sig, first_sig);
      chk("def_pass_2", {15'h0, d_pass}, 16'h1);

      // Reset mid-RUN abandons the test.
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int k = 1; k < 20; k++) tick();
      chk("midrun_busy", {15'h0, r_busy}, 16'h1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("midrst_pattern", {12'h0, r_g3, r_g2, r_g1, r_g0}, 16'h000F);
      chk("midrst_busy", {15'h0, r_busy}, 16'h0);
      chk("midrst_done", {15'h0, r_done}, 16'h0);
      chk("midrst_pass", {15'h0, d_pass}, 16'h0);
      chk("midrst_sig", r_sig, 16'h0000);
      done_seen = 0;
      for (int k = 0; k < 70; k++) begin
         if (d_done || r_done) done_seen++;
         tick();
      end
      chk("no_done_after_rst", 16'(done_seen), 16'd0);

      // START on the same edge as RST: reset wins.
      RST = 1'b1;
      START = 1'b1;
      tick();
      RST = 1'b0;
      START = 1'b0;
      chk("rst_start_busy", {15'h0, d_busy}, 16'h0);
      tick();
      chk("rst_start_busy_2", {15'h0, d_busy}, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
